chacha_stream_ctrl: RTL
=======================

CHACHA_STREAM_CTRL -- requirements
Module: chacha_stream_ctrl

Interface
REQ-001 SHALL have a single clock clk_i; rst_i SHALL be an asynchronous, active-high reset.
REQ-002 Ports (name  direction  width  meaning):
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- cfg_valid_i  in  1  session configuration strobe
- cfg_ready_o  out  1  controller can accept configuration
- key_i  in  256  session key
- nonce_i  in  96  session nonce
- counter_i  in  32  initial block counter
- din_valid_i  in  1  input byte valid
- din_ready_o  out  1  input byte accepted
- din_data_i  in  8  plaintext/ciphertext byte
- din_last_i  in  1  final byte of message
- dout_valid_o  out  1  output byte valid
- dout_ready_i  in  1  sink accepts output byte
- dout_data_o  out  8  din_data_i XOR keystream byte
- dout_last_o  out  1  final output byte
- core_key_o  out  256  key to block core
- core_nonce_o  out  96  nonce to block core
- core_counter_o  out  32  block counter to block core
- core_start_o  out  1  one-cycle block start pulse
- core_ready_i  in  1  block core idle
- core_done_i  in  1  block core finished, byte 0 present
- core_keystream_i  in  8  serialized keystream byte
- busy_o  out  1  session active
- err_o  out  1  sticky counter-exhaustion error

Function
REQ-003 SHALL implement states IDLE, KICK, WAIT, CAPTURE, STREAM, ERROR.
REQ-004 IDLE: cfg_ready_o=1; on cfg_valid_i SHALL latch key_i, nonce_i, counter_i into core_key_o/core_nonce_o/core_counter_o, clear err_o, go KICK.
REQ-005 cfg_valid_i outside IDLE SHALL be ignored (cfg_ready_o=0).
REQ-006 KICK: when core_ready_i=1, SHALL drive core_start_o=1 for exactly one cycle and go WAIT; else stay KICK.
REQ-007 WAIT: on core_done_i (cycle t) SHALL capture core_keystream_i as byte 0 and go CAPTURE.
REQ-008 CAPTURE: byte k SHALL be captured from core_keystream_i at cycle t+k, k=1..63, into a 64x8 buffer; after byte 63, read pointer=0, go STREAM.
REQ-009 STREAM: din_ready_o = (!dout_valid_o || dout_ready_i); din_ready_o SHALL be 0 in all other states.
REQ-010 On din handshake SHALL register dout_data_o = din_data_i XOR buf[rd_ptr], dout_last_o = din_last_i, dout_valid_o=1, and increment 6-bit rd_ptr; output latency one cycle.
REQ-011 dout_valid_o SHALL hold with stable data until dout_ready_i=1; a dout handshake without a new din handshake SHALL clear dout_valid_o.
REQ-012 Handshake with din_last_i=1 SHALL discard remaining buffered keystream, keep the pending output, and go IDLE once that output is accepted.
REQ-013 Handshake consuming byte 63 with din_last_i=0: if core_counter_o != 0xFFFFFFFF SHALL increment core_counter_o and go KICK; else set err_o=1 and go ERROR.
REQ-014 Counter SHALL NOT wrap; 0xFFFFFFFF is the last usable block counter.
REQ-015 ERROR: din_ready_o=0, err_o=1, pending output still delivered; SHALL return to IDLE on next cfg_valid_i after output drains (cfg_ready_o=1 when dout_valid_o=0).
REQ-016 busy_o SHALL be 1 in every state except IDLE.
REQ-017 core_done_i outside WAIT SHALL be ignored.

Reset
REQ-018 rst_i SHALL asynchronously force IDLE; cfg_ready_o=1; all other outputs, buffer pointers and latched key/nonce/counter SHALL be 0.
REQ-019 Reset mid-session SHALL abort with no further core_start_o; pending output is dropped.

Verification
REQ-020 Reset: assert rst_i mid-STREAM -> next cycle dout_valid_o=0, busy_o=0, core_counter_o=0, cfg_ready_o=1.
REQ-021 cfg key=00..1f, nonce=000000090000004a00000000, counter=1; 64 zero bytes, last on byte 64 -> one core_start_o with core_counter_o=1; dout_data_o equals captured keystream (10 f1 e7 e4 ...); dout_last_o on byte 64.
REQ-022 Same cfg, 65 bytes -> second core_start_o with core_counter_o=2; byte 65 output = din XOR byte 0 of block 2.
REQ-023 din_last_i on byte 10 -> IDLE after output accepted; new cfg -> fresh core_start_o, rd_ptr=0, no reuse of bytes 10..63.
REQ-024 counter_i=0xFFFFFFFF, 70-byte message -> after byte 64 accepted err_o=1, din_ready_o=0, no second core_start_o.
REQ-025 dout_ready_i held 0 for 5 cycles mid-stream -> dout_data_o stable, din_ready_o=0, no byte lost or duplicated.

Source files
------------

// File: rtl/chacha_stream_ctrl.sv
// Keystream controller: loads a session, requests 64-byte ChaCha blocks from an external core,
// buffers each block and XORs it byte-by-byte into the din -> dout stream.
//   state   | meaning
//   IDLE    | waiting for session configuration
//   KICK    | start pulse to block core once it is ready
//   WAIT    | waiting for core_done_i (byte 0)
//   CAPTURE | filling keystream buffer bytes 1..63
//   STREAM  | XORing input bytes; r_drain set once the last byte is taken
//   ERROR   | block counter exhausted, sticky err_o
module chacha_stream_ctrl (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         cfg_valid_i,
   output logic         cfg_ready_o,
   input  logic [255:0] key_i,
   input  logic [95:0]  nonce_i,
   input  logic [31:0]  counter_i,
   input  logic         din_valid_i,
   output logic         din_ready_o,
   input  logic [7:0]   din_data_i,
   input  logic         din_last_i,
   output logic         dout_valid_o,
   input  logic         dout_ready_i,
   output logic [7:0]   dout_data_o,
   output logic         dout_last_o,
   output logic [255:0] core_key_o,
   output logic [95:0]  core_nonce_o,
   output logic [31:0]  core_counter_o,
   output logic         core_start_o,
   input  logic         core_ready_i,
   input  logic         core_done_i,
   input  logic [7:0]   core_keystream_i,
   output logic         busy_o,
   output logic         err_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_KICK, S_WAIT, S_CAPTURE, S_STREAM, S_ERROR
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_buf [64];
   logic [5:0] r_wr_ptr;
   logic [5:0] r_rd_ptr;
   logic       r_drain;
   logic       w_din_hs;
   logic       w_dout_hs;
   logic       w_cfg_take;
   logic       w_blk_end;
   logic       w_ctr_max;

   assign w_din_hs   = din_valid_i && din_ready_o;
   assign w_dout_hs  = dout_valid_o && dout_ready_i;
   assign w_cfg_take = (r_state == S_IDLE) && cfg_valid_i;
   assign w_blk_end  = w_din_hs && !din_last_i && (r_rd_ptr == 6'd63);
   assign w_ctr_max  = (core_counter_o == 32'hFFFF_FFFF);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (cfg_valid_i) w_state_nxt = S_KICK;
         S_KICK:    if (core_ready_i) w_state_nxt = S_WAIT;
         S_WAIT:    if (core_done_i) w_state_nxt = S_CAPTURE;
         S_CAPTURE: if (r_wr_ptr == 6'd63) w_state_nxt = S_STREAM;
         S_STREAM: begin
            if (r_drain) begin
               if (!dout_valid_o || dout_ready_i) w_state_nxt = S_IDLE;
            end else if (w_blk_end) begin
               w_state_nxt = w_ctr_max ? S_ERROR : S_KICK;
            end
         end
         S_ERROR:   if (cfg_valid_i && !dout_valid_o) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cfg_ready_o  = 1'b0;
      din_ready_o  = 1'b0;
      core_start_o = 1'b0;
      busy_o       = (r_state != S_IDLE);
      case (r_state)
         S_IDLE:   cfg_ready_o  = 1'b1;
         S_KICK:   core_start_o = core_ready_i;
         S_STREAM: din_ready_o  = !r_drain && (!dout_valid_o || dout_ready_i);
         S_ERROR:  cfg_ready_o  = !dout_valid_o;
         default:  ;
      endcase
   end

   // Keystream buffer holds no reset: it is always refilled before being read.
   always_ff @(posedge clk_i) begin
      if (r_state == S_WAIT && core_done_i)
         r_buf[0] <= core_keystream_i;
      else if (r_state == S_CAPTURE)
         r_buf[r_wr_ptr] <= core_keystream_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         core_key_o     <= '0;
         core_nonce_o   <= '0;
         core_counter_o <= '0;
         err_o          <= 1'b0;
         r_drain        <= 1'b0;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         dout_valid_o   <= 1'b0;
         dout_data_o    <= '0;
         dout_last_o    <= 1'b0;
      end else begin
         if (w_cfg_take) begin
            core_key_o     <= key_i;
            core_nonce_o   <= nonce_i;
            core_counter_o <= counter_i;
            err_o          <= 1'b0;
            r_drain        <= 1'b0;
            r_rd_ptr       <= '0;
         end

         if (r_state == S_WAIT && core_done_i) begin
            r_wr_ptr <= 6'd1;
         end else if (r_state == S_CAPTURE) begin
            r_wr_ptr <= r_wr_ptr + 6'd1;
            if (r_wr_ptr == 6'd63) r_rd_ptr <= '0;
         end

         if (w_din_hs) begin
            dout_data_o  <= din_data_i ^ r_buf[r_rd_ptr];
            dout_last_o  <= din_last_i;
            dout_valid_o <= 1'b1;
            r_rd_ptr     <= r_rd_ptr + 6'd1;
            if (din_last_i) r_drain <= 1'b1;
         end else if (w_dout_hs) begin
            dout_valid_o <= 1'b0;
         end

         if (w_blk_end) begin
            if (w_ctr_max) err_o <= 1'b1;
            else           core_counter_o <= core_counter_o + 32'd1;
         end
      end
   end

endmodule
